gate_array_unit: RTL and testbench
==================================

Name: gate_array_unit

Overview:
- Parametrised, registered successor to the single 2-input AND gate: NUM_IN operands of WIDTH bits combined bitwise under a runtime-selected gate mode.
- Valid/ready handshake on input and output; one-stage output register with backpressure.
- Saturating count of accepted transactions.
- Used as the general logic-gate element for the basic-gates library and its benches.

Parameters:
- WIDTH, 8, bit width of each operand and of the result.
- NUM_IN, 2, number of operands (2..8).
- CNT_W, 16, width of the transaction counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands and mode valid this cycle.
- in_ready  output  1  unit can accept this cycle.
- mode  input  3  gate select, sampled with operands.
- in_data  input  NUM_IN*WIDTH  operand k at bits [k*WIDTH +: WIDTH].
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  registered result.
- out_any  output  1  reduction-OR of out_data.
- out_all  output  1  reduction-AND of out_data.
- txn_count  output  CNT_W  accepted input transactions, saturating.

Behaviour:
- Reset (rst_n low at a rising edge): out_valid=0, out_data=0, out_any=0, out_all=0, txn_count=0. in_ready reads 1 the cycle after reset.
- Reset mid-operation discards any held result; no partial state survives.
- Accept condition: in_valid && in_ready at a rising edge.
- in_ready = !out_valid || out_ready (combinational). A full register drains and refills in the same cycle, so there is no bubble at full throughput.
- Latency: result is visible on out_data with out_valid=1 on the cycle after acceptance.
- Hold: while out_valid && !out_ready, out_data, out_any, out_all and out_valid hold stable; in_ready=0 and inputs are ignored.
- Output handshake: out_valid clears after out_valid && out_ready if no new accept occurs that cycle.
- Mode encoding (bitwise across all NUM_IN operands):
  - 0 AND, 1 OR, 2 XOR (odd parity per bit).
  - 3 NAND, 4 NOR, 5 XNOR.
  - 6 NOT of operand 0.
  - 7 PASS operand 0.
- out_any and out_all are registered together with out_data from the same computed result.
- txn_count increments by 1 on each accept and saturates at all-ones. Saturation is terminal until reset.
- in_valid may drop without acceptance; there is no requirement to hold it.
- Mode and operands are sampled only at accept.

Optional Feature:
- Macro: GATE_ARRAY_PARITY_EN.
- Defined:
  - Extra output port out_parity (1 bit) = XOR-reduction of out_data, registered with out_data.
  - Reset value 0; holds during stall like out_data.
- Undefined:
  - Port absent; no parity logic.

Decomposition:
- Shared package gate_pkg holds:
  - Mode localparams MODE_AND..MODE_PASS (3-bit).
  - Function gate_eval(mode, a, b) for pairwise folding.
- Sub-module gate_reduce: combinational fold of NUM_IN operands under mode, instantiated once. The top holds only the handshake register and the counter.

Test Plan:
- Reset: WIDTH=4, NUM_IN=2, hold rst_n=0 for 2 cycles -> out_valid=0, out_data=4'h0, txn_count=0, in_ready=1 after release.
- Truth table: mode=AND; operand pairs (0,0), (0,F), (F,0), (F,F) at 10-cycle spacing, out_ready=1 -> out_data 0, 0, 0, F one cycle after each accept; out_all=1 only on the last.
- Mode sweep: NUM_IN=3, operands A=4'hC, B=4'hA, C=4'h6, modes 0..7 -> out_data 0, E, 0, F, 1, F, 3, C.
- Backpressure: accept one result, hold out_ready=0 for 5 cycles while in_valid=1 -> out_data stable, in_ready=0, txn_count unchanged. Release -> next operand accepted in the same cycle, no bubble.
- Throughput and saturation: CNT_W=3, in_valid=1, out_ready=1 for 10 cycles -> out_valid continuous from cycle 2, txn_count reaches 7 and stays 7.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst_n=0 for one cycle -> out_valid=0, txn_count=0 next cycle. With GATE_ARRAY_PARITY_EN, out_parity=0, and after operand 4'hB with PASS, out_parity=1.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared gate-mode encoding and the per-bit pairwise fold used by gate_reduce.
package gate_pkg;

  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_XOR  = 3'd2;
  localparam logic [2:0] MODE_NAND = 3'd3;
  localparam logic [2:0] MODE_NOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;
  localparam logic [2:0] MODE_NOT  = 3'd6;
  localparam logic [2:0] MODE_PASS = 3'd7;

  // Inverting modes fold with their base operator; the inversion is applied once
  // after the fold, otherwise NAND of three operands would not be ~(a&b&c).
  function automatic logic gate_eval(input logic [2:0] mode, input logic a, input logic b);
    case (mode)
      MODE_AND, MODE_NAND: return a & b;
      MODE_OR,  MODE_NOR:  return a | b;
      MODE_XOR, MODE_XNOR: return a ^ b;
      default:             return a;
    endcase
  endfunction

  function automatic logic gate_is_inverting(input logic [2:0] mode);
    return (mode == MODE_NAND) || (mode == MODE_NOR) ||
           (mode == MODE_XNOR) || (mode == MODE_NOT);
  endfunction

endpackage

// File: rtl/gate_array_unit_reduce.sv
// Combinational bitwise fold of NUM_IN operands under the selected gate mode.
module gate_reduce
  import gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic [2:0]              mode,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]        result
);

  logic bit_acc;

  // NOTE: every variable written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    result  = '0;
    bit_acc = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      bit_acc = in_data[i];
      for (int k = 1; k < NUM_IN; k++) begin
        bit_acc = gate_eval(mode, bit_acc, in_data[k*WIDTH + i]);
      end
      result[i] = gate_is_inverting(mode) ? ~bit_acc : bit_acc;
    end
  end

endmodule

// File: rtl/gate_array_unit.sv
// Registered NUM_IN-operand gate with valid/ready handshake and saturating accept counter.
// Optional out_parity port enabled by defining GATE_ARRAY_PARITY_EN.
module gate_array_unit
  import gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              mode,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_any,
  output logic                    out_all,
`ifdef GATE_ARRAY_PARITY_EN
  output logic                    out_parity,
`endif
  output logic [CNT_W-1:0]        txn_count
);

  logic [WIDTH-1:0] result;
  logic             accept;

  gate_reduce #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_reduce (
    .mode    (mode),
    .in_data (in_data),
    .result  (result)
  );

  // Draining and refilling in the same cycle keeps full throughput bubble-free.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_any    <= 1'b0;
      out_all    <= 1'b0;
`ifdef GATE_ARRAY_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_data   <= result;
      out_any    <= |result;
      out_all    <= &result;
`ifdef GATE_ARRAY_PARITY_EN
      out_parity <= ^result;
`endif
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn_count <= '0;
    end else if (accept && (txn_count != '1)) begin
      txn_count <= txn_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gate_array_unit.sv
// Directed self-checking bench for gate_array_unit (WIDTH=4, NUM_IN=3, CNT_W=3).
// Parity checks are compiled in when GATE_ARRAY_PARITY_EN is defined.
module tb_gate_array_unit;

  localparam int WIDTH  = 4;
  localparam int NUM_IN = 3;
  localparam int CNT_W  = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [2:0]              mode;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_any;
  logic                    out_all;
`ifdef GATE_ARRAY_PARITY_EN
  logic                    out_parity;
`endif
  logic [CNT_W-1:0]        txn_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  gate_array_unit #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode       (mode),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_any    (out_any),
    .out_all    (out_all),
`ifdef GATE_ARRAY_PARITY_EN
    .out_parity (out_parity),
`endif
    .txn_count  (txn_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_inc(input int c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 3'd0; in_data = '0;
    step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 4'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if (txn_count !== 3'd0) begin bad++; $display("FAIL reset_txn_count got=%0d want=0", txn_count); end
    total++; if (out_any !== 1'b0 || out_all !== 1'b0) begin bad++; $display("FAIL reset_any_all got=%b%b want=00", out_any, out_all); end
`ifdef GATE_ARRAY_PARITY_EN
    total++; if (out_parity !== 1'b0) begin bad++; $display("FAIL reset_parity got=%b want=0", out_parity); end
`endif
    rst_n = 1'b1;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    exp_cnt = 0;
  endtask

  // Third operand tied to F so the 3-input AND reduces to the 2-input truth table.
  task automatic test_truth_table();
    logic [3:0] va [4] = '{4'h0, 4'h0, 4'hF, 4'hF};
    logic [3:0] vb [4] = '{4'h0, 4'hF, 4'h0, 4'hF};
    logic [3:0] ve [4] = '{4'h0, 4'h0, 4'h0, 4'hF};
    mode = 3'd0; out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      in_data = {4'hF, vb[v], va[v]}; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      exp_cnt = sat_inc(exp_cnt);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL tt_valid[%0d] got=%b want=1", v, out_valid); end
      total++; if (out_data !== ve[v]) begin bad++; $display("FAIL tt_data[%0d] got=%h want=%h", v, out_data, ve[v]); end
      total++; if (out_all !== (ve[v] == 4'hF)) begin bad++; $display("FAIL tt_all[%0d] got=%b want=%b", v, out_all, ve[v] == 4'hF); end
      total++; if (out_any !== (ve[v] != 4'h0)) begin bad++; $display("FAIL tt_any[%0d] got=%b want=%b", v, out_any, ve[v] != 4'h0); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL tt_drain[%0d] got=%b want=0", v, out_valid); end
      for (int i = 0; i < 8; i++) step();
    end
    total++; if (txn_count !== 3'(exp_cnt)) begin bad++; $display("FAIL tt_count got=%0d want=%0d", txn_count, exp_cnt); end
  endtask

  task automatic test_backpressure();
    mode = 3'd2; out_ready = 1'b0;
    in_data = {4'h0, 4'h0, 4'h5}; in_valid = 1'b1;
    step();
    exp_cnt = sat_inc(exp_cnt);
    in_data = {4'h0, 4'h0, 4'h9};
    for (int i = 0; i < 5; i++) begin
      total++; if (out_data !== 4'h5 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold[%0d] got=%h/%b want=5/1", i, out_data, out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=0", i, in_ready); end
      total++; if (txn_count !== 3'(exp_cnt)) begin bad++; $display("FAIL bp_count[%0d] got=%0d want=%0d", i, txn_count, exp_cnt); end
      step();
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
    step();
    exp_cnt = sat_inc(exp_cnt);
    in_valid = 1'b0;
    total++; if (out_data !== 4'h9 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_refill got=%h/%b want=9/1", out_data, out_valid); end
    total++; if (txn_count !== 3'(exp_cnt)) begin bad++; $display("FAIL bp_refill_count got=%0d want=%0d", txn_count, exp_cnt); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    mode = 3'd7; out_ready = 1'b0;
    in_data = {4'h0, 4'h0, 4'h3}; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 4'h3) begin bad++; $display("FAIL ms_stalled got=%b/%h want=1/3", out_valid, out_data); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_cnt = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ms_out_valid got=%b want=0", out_valid); end
    total++; if (txn_count !== 3'd0) begin bad++; $display("FAIL ms_count got=%0d want=0", txn_count); end
    total++; if (out_data !== 4'h0) begin bad++; $display("FAIL ms_out_data got=%h want=0", out_data); end
`ifdef GATE_ARRAY_PARITY_EN
    total++; if (out_parity !== 1'b0) begin bad++; $display("FAIL ms_parity_reset got=%b want=0", out_parity); end
`endif
    out_ready = 1'b1;
    mode = 3'd7; in_data = {4'h0, 4'h0, 4'hB}; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    exp_cnt = sat_inc(exp_cnt);
    total++; if (out_data !== 4'hB) begin bad++; $display("FAIL ms_pass got=%h want=b", out_data); end
`ifdef GATE_ARRAY_PARITY_EN
    total++; if (out_parity !== 1'b1) begin bad++; $display("FAIL ms_parity got=%b want=1", out_parity); end
`endif
    step();
  endtask

  task automatic test_mode_sweep();
    logic [3:0] sweep_exp [8] = '{4'h0, 4'hE, 4'h0, 4'hF, 4'h1, 4'hF, 4'h3, 4'hC};
    out_ready = 1'b1;
    in_data = {4'h6, 4'hA, 4'hC};
    for (int m = 0; m < 8; m++) begin
      mode = 3'(m); in_valid = 1'b1;
      step();
      exp_cnt = sat_inc(exp_cnt);
      total++; if (out_valid !== 1'b1 || out_data !== sweep_exp[m]) begin bad++; $display("FAIL sweep_mode%0d got=%h/%b want=%h/1", m, out_data, out_valid, sweep_exp[m]); end
    end
    in_valid = 1'b0;
    total++; if (txn_count !== 3'(exp_cnt)) begin bad++; $display("FAIL sweep_count got=%0d want=%0d", txn_count, exp_cnt); end
    step();
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0; in_valid = 1'b0;
    step();
    rst_n = 1'b1; exp_cnt = 0;
    step();
    mode = 3'd7; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data = {4'h0, 4'h0, 4'(c)}; in_valid = 1'b1;
      step();
      exp_cnt = sat_inc(exp_cnt);
      total++; if (out_valid !== 1'b1 || out_data !== 4'(c)) begin bad++; $display("FAIL b2b_data[%0d] got=%h/%b want=%h/1", c, out_data, out_valid, 4'(c)); end
      total++; if (txn_count !== 3'(exp_cnt)) begin bad++; $display("FAIL b2b_count[%0d] got=%0d want=%0d", c, txn_count, exp_cnt); end
    end
    in_valid = 1'b0;
    step(); step();
    total++; if (txn_count !== 3'd7) begin bad++; $display("FAIL sat_hold got=%0d want=7", txn_count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_backpressure();
    test_reset_mid_stall();
    test_mode_sweep();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
